// File: rtl/alu_sru_wide_if.sv
// alu_sru_wide_if: start/busy/done request bus for the wide shift/rotate unit.
// The master drives the operands and op bits; the slave returns the result, the link value and the strobes.
interface alu_sru_wide_if #(
  parameter int WIDTH  = 16,
  parameter int DIST_W = 4
);
  logic              start;
  logic [WIDTH-1:0]  b;
  logic              fl_in;
  logic [DIST_W-1:0] op_dist;
  logic              op_right;
  logic              op_arithmetic;
  logic              op_rotate;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              fl_out;
  logic              fl_we;

  modport master (
    output start, b, fl_in, op_dist, op_right, op_arithmetic, op_rotate,
    input  busy, done, result, fl_out, fl_we
  );

  modport slave (
    input  start, b, fl_in, op_dist, op_right, op_arithmetic, op_rotate,
    output busy, done, result, fl_out, fl_we
  );
endinterface

// File: rtl/alu_sru_wide.sv
// alu_sru_wide: shift/rotate-through-link, STRIDE bits/cycle, done after ceil(dist/STRIDE)+1 cycles (1 with SRU_BARREL_EN).
// start is taken only in IDLE; requests while busy are dropped, not queued.
module alu_sru_wide #(
  parameter int WIDTH  = 16,
  parameter int DIST_W = 4,
  parameter int STRIDE = 1
) (
  input logic           clk4,
  input logic           reset,
  alu_sru_wide_if.slave bus
);
`ifdef SRU_BARREL_EN
  localparam int LOOP_N = (1 << DIST_W) - 1;
`else
  localparam int LOOP_N = STRIDE;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] result_q;
  logic             link_q;
  logic             zero_dist_q;
  logic [WIDTH:0]   stepped;

  // Applies n single-position steps to {link, value}; returns {new_link, new_value}.
  function automatic logic [WIDTH:0] sru_shift(
    input logic [WIDTH-1:0] val,
    input logic             lnk,
    input int               n,
    input logic             right,
    input logic             arith,
    input logic             rot
  );
    logic [WIDTH-1:0] r;
    logic             l;
    logic             fill;
    r    = val;
    l    = lnk;
    fill = 1'b0;
    for (int i = 0; i < LOOP_N; i++) begin
      if (i < n) begin
        if (right) begin
          fill = rot ? l : (arith & r[WIDTH-1]);
          l    = r[0];
          r    = {fill, r[WIDTH-1:1]};
        end else begin
          fill = rot ? l : 1'b0;
          l    = r[WIDTH-1];
          r    = {r[WIDTH-2:0], fill};
        end
      end
    end
    return {l, r};
  endfunction

`ifdef SRU_BARREL_EN
  assign stepped = sru_shift(bus.b, bus.fl_in, int'(bus.op_dist),
                             bus.op_right, bus.op_arithmetic, bus.op_rotate);
`else
  logic [DIST_W-1:0] cnt_q;
  logic              op_right_q;
  logic              op_arith_q;
  logic              op_rot_q;
  int                step_n;

  always_comb begin
    step_n  = (int'(cnt_q) < STRIDE) ? int'(cnt_q) : STRIDE;
    stepped = sru_shift(result_q, link_q, step_n, op_right_q, op_arith_q, op_rot_q);
  end
`endif

  always_ff @(posedge clk4) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SRU_BARREL_EN
          state_nxt = DONE;
`else
          state_nxt = (bus.op_dist == '0) ? DONE : RUN;
`endif
        end
      end
`ifndef SRU_BARREL_EN
      RUN:  state_nxt = (cnt_q == DIST_W'(step_n)) ? DONE : RUN;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk4) begin
    if (reset) begin
      result_q    <= '0;
      link_q      <= 1'b0;
      zero_dist_q <= 1'b0;
`ifndef SRU_BARREL_EN
      cnt_q       <= '0;
      op_right_q  <= 1'b0;
      op_arith_q  <= 1'b0;
      op_rot_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            zero_dist_q <= (bus.op_dist == '0);
`ifdef SRU_BARREL_EN
            {link_q, result_q} <= stepped;
`else
            result_q   <= bus.b;
            link_q     <= bus.fl_in;
            cnt_q      <= bus.op_dist;
            op_right_q <= bus.op_right;
            op_arith_q <= bus.op_arithmetic;
            op_rot_q   <= bus.op_rotate;
`endif
          end
        end
`ifndef SRU_BARREL_EN
        RUN: begin
          {link_q, result_q} <= stepped;
          cnt_q              <= cnt_q - DIST_W'(step_n);
        end
`endif
        default: ;
      endcase
    end
  end

  // A zero-distance op leaves the link untouched, so it gets no write strobe.
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.fl_we  = (state == DONE) && !zero_dist_q;
  assign bus.result = result_q;
  assign bus.fl_out = link_q;
endmodule
